pwm_compare_deadtime: RTL and testbench
=======================================

Name: pwm_compare_deadtime

Overview:
Downstream consumer of the period counter master. Compares the live 16-bit counter value against a double-buffered duty register and produces a complementary high/low PWM pair with programmable dead-time. Duty updates are shadowed and committed only on the master's sync (period) event, so no glitched periods occur.

Parameters:
WIDTH, 16, counter/duty width; must match the period counter.
DT_WIDTH, 8, dead-time counter width in clock cycles.

Ports:
i_clk  in  1  clock
i_reset  in  1  reset
i_en  in  1  clock enable; same enable as the period counter; low freezes all state
i_counter  in  WIDTH  current period counter value
i_sync  in  1  period event from the counter master (unqualified sync, 1 cycle)
i_mode  in  2  counter mode (00 OFF, 01 UP, 10 DOWN, 11 UP_DOWN)
i_duty  in  WIDTH  new duty/compare value
i_duty_wr  in  1  write strobe for i_duty into shadow
i_deadtime  in  DT_WIDTH  dead-time in cycles
i_out_en  in  1  output enable; low forces both outputs inactive
i_polarity  in  1  0 active-high outputs, 1 active-low outputs
o_pwm_h  out  1  high-side output
o_pwm_l  out  1  low-side output
o_duty_active  out  WIDTH  committed duty value
o_load_done  out  1  1-cycle pulse when shadow committed

Behaviour:
- Reset (i_reset, asynchronous, active-high; clock i_clk): shadow=0, active=0, pending=0, FSM=S_OFF, dt counter=0, o_load_done=0; o_pwm_h=o_pwm_l=i_polarity (inactive).
- i_en low: no register updates, except i_duty_wr is still captured into shadow (bus-side write). Outputs hold.
- Shadow: i_duty_wr -> shadow<=i_duty, pending<=1. On i_en & i_sync & pending: active<=shadow, pending<=0, o_load_done=1 next cycle. Write and sync in the same cycle: i_duty bypasses directly to active; pending ends 0.
- Raw compare (combinational): raw = (i_mode!=OFF) & (i_counter < active). active=0 -> raw always 0. active>period -> raw always 1.
- FSM states: S_OFF (H=0,L=0), S_H (H=1), S_L (L=1), S_DT_HL (both 0, H->L), S_DT_LH (both 0, L->H).
- Transitions (only when i_en=1):
  - Any state, i_out_en=0 -> S_OFF.
  - S_OFF: raw ? S_H : S_L (both already off, no dead-time).
  - S_H: !raw -> S_DT_HL, dt<=i_deadtime; if i_deadtime==0 -> S_L directly.
  - S_L: raw -> S_DT_LH, dt<=i_deadtime; if 0 -> S_H directly.
  - S_DT_HL: dt==1 -> S_L, else dt--; raw reasserts -> S_H (abort, H was last on, safe).
  - S_DT_LH: dt==1 -> S_H, else dt--; raw deasserts -> S_L (abort).
- Dead-time length: exactly i_deadtime cycles with both outputs inactive. i_deadtime is sampled on dead-time entry only.
- Outputs: o_pwm_h = (state==S_H) ^ i_polarity; o_pwm_l = (state==S_L) ^ i_polarity. Both are driven from the state register, so they are glitch-free with 1 cycle latency from i_counter crossing.
- Invariant: H and L are never active simultaneously.

Optional Feature:
Macro PWM_FAULT_EN.
- With the macro: adds ports i_fault (in, 1), i_fault_clr (in, 1) and o_fault (out, 1).
  - i_fault high latches fault asynchronously to the enable (evaluated every clock, regardless of i_en) and forces S_OFF on the next clock.
  - o_fault is sticky.
  - i_fault_clr with i_fault low clears the latch; the FSM resumes from S_OFF.
  - Fault has priority over i_out_en.
- Without the macro: ports absent, no fault logic.

Decomposition:
- Shared package pwm_pkg: mode localparams (MODE_OFF/UP/DOWN/UP_DOWN) shared with the counter master; FSM state encoding (3-bit).
- One natural sub-module: pwm_deadtime_gen (FSM plus dt counter; inputs raw, out_en, deadtime; outputs h/l).
- Compare and shadow logic stay in the top module.

Test Plan:
- Shadow commit: UP mode, period=9, write duty=4 mid-period -> active stays 0 until i_sync, then 4; o_load_done pulses once.
- Basic PWM: duty=4, deadtime=0, period=9 -> H high for counter 0..3 (seen 1 cycle later), L high for 4..9, never both.
- Dead-time: duty=4, deadtime=2 -> exactly 2 cycles both-low at each H->L and L->H edge; H pulse shortened to 2 cycles.
- Abort/boundary: duty=0 -> L constant; duty=10 with period=9 -> H constant; deadtime=5 with 3-cycle high window -> H never asserts, L is restored.
- Control: i_out_en=0 mid-H -> both inactive next cycle; i_polarity=1 -> outputs inverted, reset outputs =1; i_en=0 freezes outputs and dt count.
- PWM_FAULT_EN: assert i_fault during S_H -> both inactive next cycle, o_fault=1; pulse i_fault_clr with fault low -> resumes normally.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM slice: counter mode encodings used by the period
// counter master, and the 3-bit state encoding of the dead-time generator.
package pwm_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_UP      = 2'b01;
  localparam logic [1:0] MODE_DOWN    = 2'b10;
  localparam logic [1:0] MODE_UP_DOWN = 2'b11;

  typedef enum logic [2:0] {
    StOff  = 3'd0,
    StH    = 3'd1,
    StL    = 3'd2,
    StDtHl = 3'd3,
    StDtLh = 3'd4
  } pwm_state_e;

endpackage

// File: rtl/pwm_deadtime_gen.sv
// Complementary output FSM with programmable dead-time between H and L phases.
// h/l are active-high here; polarity is applied by the parent.
module pwm_deadtime_gen
  import pwm_pkg::*;
#(
  parameter int unsigned DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                kill,
  input  logic                raw,
  input  logic                out_en,
  input  logic [DT_WIDTH-1:0] deadtime,
  output logic                h,
  output logic                l
);

  pwm_state_e          state_q, state_d;
  logic [DT_WIDTH-1:0] dt_q, dt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StOff;
      dt_q    <= '0;
    end else begin
      state_q <= state_d;
      dt_q    <= dt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    // kill bypasses the enable so a fault shuts the outputs even when frozen
    if (kill) begin
      state_d = StOff;
    end else if (en) begin
      if (!out_en) begin
        state_d = StOff;
      end else begin
        unique case (state_q)
          StOff: state_d = raw ? StH : StL;
          StH: begin
            if (!raw) begin
              if (deadtime == '0) begin
                state_d = StL;
              end else begin
                state_d = StDtHl;
                dt_d    = deadtime;
              end
            end
          end
          StL: begin
            if (raw) begin
              if (deadtime == '0) begin
                state_d = StH;
              end else begin
                state_d = StDtLh;
                dt_d    = deadtime;
              end
            end
          end
          StDtHl: begin
            if (raw) begin
              state_d = StH;
            end else if (dt_q == DT_WIDTH'(1)) begin
              state_d = StL;
            end else begin
              dt_d = dt_q - DT_WIDTH'(1);
            end
          end
          StDtLh: begin
            if (!raw) begin
              state_d = StL;
            end else if (dt_q == DT_WIDTH'(1)) begin
              state_d = StH;
            end else begin
              dt_d = dt_q - DT_WIDTH'(1);
            end
          end
          default: state_d = StOff;
        endcase
      end
    end
  end

  always_comb begin
    h = (state_q == StH);
    l = (state_q == StL);
  end

endmodule

// File: rtl/pwm_compare_deadtime.sv
// Compare stage: double-buffered duty, counter compare and complementary PWM with dead-time.
// Define PWM_FAULT_EN to add the sticky fault input/clear/output.
module pwm_compare_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DT_WIDTH = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic [WIDTH-1:0]    i_counter,
  input  logic                i_sync,
  input  logic [1:0]          i_mode,
  input  logic [WIDTH-1:0]    i_duty,
  input  logic                i_duty_wr,
  input  logic [DT_WIDTH-1:0] i_deadtime,
  input  logic                i_out_en,
  input  logic                i_polarity,
`ifdef PWM_FAULT_EN
  input  logic                i_fault,
  input  logic                i_fault_clr,
  output logic                o_fault,
`endif
  output logic                o_pwm_h,
  output logic                o_pwm_l,
  output logic [WIDTH-1:0]    o_duty_active,
  output logic                o_load_done
);

  logic [WIDTH-1:0] shadow_q, active_q;
  logic             pending_q, load_done_q;
  logic             commit, raw, kill, h, l;

  // A write coinciding with sync commits immediately, even with nothing pending
  assign commit = i_en & i_sync & (pending_q | i_duty_wr);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shadow_q    <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      if (i_duty_wr) begin
        shadow_q <= i_duty;
      end
      if (commit) begin
        active_q  <= i_duty_wr ? i_duty : shadow_q;
        pending_q <= 1'b0;
      end else if (i_duty_wr) begin
        pending_q <= 1'b1;
      end
      load_done_q <= commit;
    end
  end

  always_comb begin
    raw = (i_mode != MODE_OFF) && (i_counter < active_q);
  end

`ifdef PWM_FAULT_EN
  logic fault_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fault_q <= 1'b0;
    end else if (i_fault) begin
      fault_q <= 1'b1;
    end else if (i_fault_clr) begin
      fault_q <= 1'b0;
    end
  end

  assign kill    = i_fault | fault_q;
  assign o_fault = fault_q;
`else
  assign kill = 1'b0;
`endif

  pwm_deadtime_gen #(
    .DT_WIDTH(DT_WIDTH)
  ) u_deadtime_gen (
    .clk     (i_clk),
    .reset   (i_reset),
    .en      (i_en),
    .kill    (kill),
    .raw     (raw),
    .out_en  (i_out_en),
    .deadtime(i_deadtime),
    .h       (h),
    .l       (l)
  );

  assign o_pwm_h       = h ^ i_polarity;
  assign o_pwm_l       = l ^ i_polarity;
  assign o_duty_active = active_q;
  assign o_load_done   = load_done_q;

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// Directed bench for pwm_compare_deadtime: vector table plus PWM sweep and fault sequences.
module tb_pwm_compare_deadtime;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] counter;
  logic        sync;
  logic [1:0]  mode;
  logic [15:0] duty;
  logic        duty_wr;
  logic [7:0]  deadtime;
  logic        out_en;
  logic        polarity;
  logic        pwm_h;
  logic        pwm_l;
  logic [15:0] duty_active;
  logic        load_done;
`ifdef PWM_FAULT_EN
  logic        fault;
  logic        fault_clr;
  logic        fault_out;
`endif

  int n_pass  = 0;
  int n_total = 0;

  pwm_compare_deadtime #(
    .WIDTH   (16),
    .DT_WIDTH(8)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_en         (en),
    .i_counter    (counter),
    .i_sync       (sync),
    .i_mode       (mode),
    .i_duty       (duty),
    .i_duty_wr    (duty_wr),
    .i_deadtime   (deadtime),
    .i_out_en     (out_en),
    .i_polarity   (polarity),
`ifdef PWM_FAULT_EN
    .i_fault      (fault),
    .i_fault_clr  (fault_clr),
    .o_fault      (fault_out),
`endif
    .o_pwm_h      (pwm_h),
    .o_pwm_l      (pwm_l),
    .o_duty_active(duty_active),
    .o_load_done  (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] cnt;
    logic        sync;
    logic        wr;
    logic [15:0] duty;
    logic [7:0]  dt;
    logic        oe;
    logic        pol;
    logic [1:0]  mode;
    logic        eh;
    logic        el;
    logic [15:0] ea;
    logic        eld;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t vec(input logic v_en, input int v_cnt, input logic v_sync,
                               input logic v_wr, input int v_duty, input int v_dt,
                               input logic v_oe, input logic v_pol, input int v_mode,
                               input logic v_eh, input logic v_el, input int v_ea,
                               input logic v_eld);
    vec_t v;
    v.en   = v_en;
    v.cnt  = 16'(v_cnt);
    v.sync = v_sync;
    v.wr   = v_wr;
    v.duty = 16'(v_duty);
    v.dt   = 8'(v_dt);
    v.oe   = v_oe;
    v.pol  = v_pol;
    v.mode = 2'(v_mode);
    v.eh   = v_eh;
    v.el   = v_el;
    v.ea   = 16'(v_ea);
    v.eld  = v_eld;
    return v;
  endfunction

  task automatic check(input string name, input logic eh, input logic el,
                       input logic [15:0] ea, input logic eld);
    n_total++;
    if (pwm_h === eh && pwm_l === el && duty_active === ea && load_done === eld) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got h=%0b l=%0b active=%0d load_done=%0b, expected h=%0b l=%0b active=%0d load_done=%0b",
               name, pwm_h, pwm_l, duty_active, load_done, eh, el, ea, eld);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    en       = v.en;
    counter  = v.cnt;
    sync     = v.sync;
    duty_wr  = v.wr;
    duty     = v.duty;
    deadtime = v.dt;
    out_en   = v.oe;
    polarity = v.pol;
    mode     = v.mode;
  endtask

  initial begin
    int cnt_h;
    int cnt_l;
    int cnt_both;

    rst = 1'b1; en = 1'b0; counter = '0; sync = 1'b0; mode = 2'b01; duty = '0;
    duty_wr = 1'b0; deadtime = '0; out_en = 1'b1; polarity = 1'b0;
`ifdef PWM_FAULT_EN
    fault = 1'b0; fault_clr = 1'b0;
`endif

    //      en cnt sy wr duty dt oe pol mode   h  l  act ld
    vecs.push_back(vec(1, 0, 0, 1, 4,  0, 1, 0, 1,  0, 1, 0,  0)); // shadow write, Off->L
    vecs.push_back(vec(1, 1, 0, 0, 0,  0, 1, 0, 1,  0, 1, 0,  0));
    vecs.push_back(vec(1, 2, 0, 0, 0,  0, 1, 0, 1,  0, 1, 0,  0)); // still not committed
    vecs.push_back(vec(1, 9, 1, 0, 0,  0, 1, 0, 1,  0, 1, 4,  1)); // commit on sync
    vecs.push_back(vec(1, 0, 0, 0, 0,  0, 1, 0, 1,  1, 0, 4,  0));
    vecs.push_back(vec(1, 1, 0, 0, 0,  0, 1, 0, 1,  1, 0, 4,  0));
    vecs.push_back(vec(1, 2, 0, 0, 0,  0, 1, 0, 1,  1, 0, 4,  0));
    vecs.push_back(vec(1, 3, 0, 0, 0,  0, 1, 0, 1,  1, 0, 4,  0));
    vecs.push_back(vec(1, 4, 0, 0, 0,  0, 1, 0, 1,  0, 1, 4,  0));
    vecs.push_back(vec(1, 5, 0, 0, 0,  0, 1, 0, 1,  0, 1, 4,  0));
    vecs.push_back(vec(1, 9, 1, 0, 0,  2, 1, 0, 1,  0, 1, 4,  0)); // sync, nothing pending
    vecs.push_back(vec(1, 0, 0, 0, 0,  2, 1, 0, 1,  0, 0, 4,  0)); // L->H dead-time
    vecs.push_back(vec(1, 1, 0, 0, 0,  2, 1, 0, 1,  0, 0, 4,  0));
    vecs.push_back(vec(1, 2, 0, 0, 0,  2, 1, 0, 1,  1, 0, 4,  0));
    vecs.push_back(vec(1, 3, 0, 0, 0,  2, 1, 0, 1,  1, 0, 4,  0));
    vecs.push_back(vec(1, 4, 0, 0, 0,  2, 1, 0, 1,  0, 0, 4,  0)); // H->L dead-time
    vecs.push_back(vec(1, 5, 0, 0, 0,  2, 1, 0, 1,  0, 0, 4,  0));
    vecs.push_back(vec(1, 6, 0, 0, 0,  2, 1, 0, 1,  0, 1, 4,  0));
    vecs.push_back(vec(0, 7, 0, 1, 3,  2, 1, 0, 1,  0, 1, 4,  0)); // write while disabled
    vecs.push_back(vec(0, 0, 1, 0, 0,  2, 1, 0, 1,  0, 1, 4,  0)); // sync ignored, no move
    vecs.push_back(vec(1, 9, 1, 0, 0,  5, 1, 0, 1,  0, 1, 3,  1));
    vecs.push_back(vec(1, 0, 0, 0, 0,  5, 1, 0, 1,  0, 0, 3,  0)); // dt=5 > high window
    vecs.push_back(vec(1, 1, 0, 0, 0,  5, 1, 0, 1,  0, 0, 3,  0));
    vecs.push_back(vec(1, 2, 0, 0, 0,  5, 1, 0, 1,  0, 0, 3,  0));
    vecs.push_back(vec(1, 3, 0, 0, 0,  5, 1, 0, 1,  0, 1, 3,  0)); // abort back to L
    vecs.push_back(vec(1, 4, 0, 0, 0,  5, 1, 0, 1,  0, 1, 3,  0));
    vecs.push_back(vec(1, 9, 0, 0, 0,  2, 1, 0, 1,  0, 1, 3,  0));
    vecs.push_back(vec(1, 0, 0, 0, 0,  2, 1, 0, 1,  0, 0, 3,  0));
    vecs.push_back(vec(0, 1, 0, 0, 0,  2, 1, 0, 1,  0, 0, 3,  0)); // dt count frozen
    vecs.push_back(vec(0, 1, 0, 0, 0,  2, 1, 0, 1,  0, 0, 3,  0));
    vecs.push_back(vec(1, 1, 0, 0, 0,  2, 1, 0, 1,  0, 0, 3,  0));
    vecs.push_back(vec(1, 2, 0, 0, 0,  2, 1, 0, 1,  1, 0, 3,  0));
    vecs.push_back(vec(1, 2, 0, 0, 0,  2, 0, 0, 1,  0, 0, 3,  0)); // out_en low mid-H
    vecs.push_back(vec(1, 5, 0, 0, 0,  2, 0, 0, 1,  0, 0, 3,  0));
    vecs.push_back(vec(1, 0, 0, 0, 0,  2, 1, 0, 1,  1, 0, 3,  0)); // Off->H, no dead-time
    vecs.push_back(vec(1, 1, 0, 0, 0,  2, 1, 1, 1,  0, 1, 3,  0)); // inverted polarity
    vecs.push_back(vec(1, 3, 0, 0, 0,  2, 1, 0, 1,  0, 0, 3,  0));
    vecs.push_back(vec(1, 4, 1, 1, 0,  2, 1, 0, 1,  0, 0, 0,  1)); // write+sync bypass
    vecs.push_back(vec(1, 5, 0, 0, 0,  2, 1, 0, 1,  0, 1, 0,  0));
    vecs.push_back(vec(1, 0, 0, 0, 0,  2, 1, 0, 1,  0, 1, 0,  0)); // duty 0: L constant
    vecs.push_back(vec(1, 9, 1, 0, 0,  2, 1, 0, 1,  0, 1, 0,  0));
    vecs.push_back(vec(1, 9, 1, 1, 10, 0, 1, 0, 1,  0, 1, 10, 1));
    vecs.push_back(vec(1, 0, 0, 0, 0,  0, 1, 0, 1,  1, 0, 10, 0)); // duty > period: H
    vecs.push_back(vec(1, 9, 0, 0, 0,  0, 1, 0, 1,  1, 0, 10, 0));
    vecs.push_back(vec(1, 5, 0, 0, 0,  0, 1, 0, 0,  0, 1, 10, 0)); // mode OFF
    vecs.push_back(vec(1, 5, 0, 0, 0,  0, 1, 0, 1,  1, 0, 10, 0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 1'b0, 16'd0, 1'b0);
`ifdef PWM_FAULT_EN
    check_val("reset_fault", int'(fault_out), 0);
`endif
    polarity = 1'b1;
    #1;
    check("reset_inverted", 1'b1, 1'b1, 16'd0, 1'b0);
    polarity = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      check($sformatf("vec%0d", i), vecs[i].eh, vecs[i].el, vecs[i].ea, vecs[i].eld);
    end

    // Sweep: duty 4, dead-time 2, period 9; skip the first period while it settles
    en = 1'b1; mode = 2'b01; out_en = 1'b1; polarity = 1'b0;
    counter = 16'd9; sync = 1'b1; duty_wr = 1'b1; duty = 16'd4; deadtime = 8'd2;
    tick();
    duty_wr = 1'b0;
    cnt_h = 0; cnt_l = 0; cnt_both = 0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 10; c++) begin
        counter = 16'(c);
        sync    = (c == 9);
        tick();
        if (p > 0) begin
          cnt_h    += int'(pwm_h);
          cnt_l    += int'(pwm_l);
          cnt_both += int'(pwm_h & pwm_l);
        end
      end
    end
    check_val("sweep_h_cycles", cnt_h, 4);
    check_val("sweep_l_cycles", cnt_l, 8);
    check_val("sweep_overlap", cnt_both, 0);

`ifdef PWM_FAULT_EN
    sync = 1'b0; deadtime = 8'd0; counter = 16'd0;
    tick();
    check("fault_pre_h", 1'b1, 1'b0, 16'd4, 1'b0);
    fault = 1'b1; counter = 16'd1;
    tick();
    check("fault_off", 1'b0, 1'b0, 16'd4, 1'b0);
    check_val("fault_latched", int'(fault_out), 1);
    fault = 1'b0; counter = 16'd2;
    tick();
    check("fault_sticky_off", 1'b0, 1'b0, 16'd4, 1'b0);
    check_val("fault_sticky", int'(fault_out), 1);
    fault_clr = 1'b1;
    tick();
    check_val("fault_cleared", int'(fault_out), 0);
    fault_clr = 1'b0; counter = 16'd3;
    tick();
    check("fault_resume", 1'b1, 1'b0, 16'd4, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
